detector_rr_arbiter: RTL

Round-robin scheduler that shares one `detector_110101` instance among `N_CH` serial channels. It grants one requesting channel at a time and flushes the detector before each grant. It steers the granted channel's bitstream into the detector, holds the grant through the detector's full output window, then rotates priority. It sits between the channel front-ends and the single detector, and re-exports the detector output tagged with its channel index.

---
 rtl/detector_arb_pkg.sv | 15 +
 rtl/detector_rr_arbiter_rr_pick.sv | 37 +++
 rtl/detector_rr_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/detector_arb_pkg.sv
// Shared types and defaults for the round-robin detector arbiter.
package detector_arb_pkg;

    localparam int ARB_N_CH_DEFAULT    = 4;
    localparam int ARB_TIMEOUT_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_HUNT    = 3'd2,
        ST_XFER    = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_t;

endpackage

// File: rtl/detector_rr_arbiter_rr_pick.sv
// Combinational cyclic priority pick: first set bit of req at or after ptr.
import detector_arb_pkg::*;

module rr_pick #(
    parameter int N_CH = ARB_N_CH_DEFAULT
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] ptr,
    output logic [$clog2(N_CH)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(N_CH);

    logic [N_CH-1:0] hit;
    logic [IW-1:0]   cand [N_CH];

    // cand[gi] is the channel sitting gi places after ptr, wrapped mod N_CH
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_off
        logic [IW:0] sum;
        assign sum      = {1'b0, ptr} + (IW+1)'(gi);
        assign cand[gi] = (sum >= (IW+1)'(N_CH)) ? IW'(sum - (IW+1)'(N_CH)) : sum[IW-1:0];
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/detector_rr_arbiter.sv
// Shares one external detector_110101 among N_CH serial channels with
// round-robin grants, a flush before each grant and a HUNT timeout.
import detector_arb_pkg::*;

module detector_rr_arbiter #(
    parameter int N_CH    = ARB_N_CH_DEFAULT,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH-1:0]         ser_in_ch,
    input  logic                    det_ser_out,
    input  logic                    det_ser_out_valid,
    output logic                    det_ser_in,
    output logic                    det_clk_en,
    output logic                    det_rst,
    output logic [N_CH-1:0]         gnt,
    output logic [$clog2(N_CH)-1:0] gnt_idx,
    output logic                    ser_out,
    output logic                    ser_out_valid,
    output logic                    done,
    output logic                    done_timeout
);

    localparam int IW = $clog2(N_CH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t    state_reg, state_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [IW-1:0] gnt_idx_reg, gnt_idx_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          tmo_reg, tmo_next;

    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          routing;
    logic          granted;

    rr_pick #(.N_CH(N_CH)) u_pick (
        .req (req),
        .ptr (ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnt_idx_next = gnt_idx_reg;
        cnt_next     = cnt_reg;
        tmo_next     = tmo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_idx_next = pick_idx;
                    cnt_next     = '0;
                    tmo_next     = 1'b0;
                    state_next   = ST_FLUSH;
                end
            end
            ST_FLUSH: state_next = ST_HUNT;
            ST_HUNT: begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                // detection outranks both request drop and timeout
                if (det_ser_out_valid) begin
                    state_next = ST_XFER;
                end else if (!req[gnt_idx_reg]) begin
                    state_next = ST_RELEASE;
                end else if (cnt_reg >= CNT_LAST) begin
                    state_next = ST_RELEASE;
                    tmo_next   = 1'b1;
                end
            end
            ST_XFER: begin
                if (!det_ser_out_valid) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                ptr_next   = (gnt_idx_reg == IW'(N_CH - 1)) ? '0 : gnt_idx_reg + 1'b1;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            gnt_idx_reg <= '0;
            cnt_reg     <= '0;
            tmo_reg     <= 1'b0;
        end else if (clk_en) begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_idx_reg <= gnt_idx_next;
            cnt_reg     <= cnt_next;
            tmo_reg     <= tmo_next;
        end
    end

    assign routing = (state_reg == ST_HUNT) || (state_reg == ST_XFER);
    assign granted = routing || (state_reg == ST_FLUSH);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_gnt
        assign gnt[gi] = granted && (gnt_idx_reg == IW'(gi));
    end

    assign gnt_idx       = gnt_idx_reg;
    assign det_ser_in    = routing && ser_in_ch[gnt_idx_reg];
    assign det_clk_en    = routing && clk_en;
    assign det_rst       = rst || (state_reg == ST_FLUSH);
    assign ser_out       = det_ser_out;
    assign ser_out_valid = det_ser_out_valid && (state_reg == ST_XFER);
    // RELEASE only completes on an enabled cycle, so the pulse is qualified by clk_en
    assign done          = clk_en && (state_reg == ST_RELEASE);
    assign done_timeout  = done && tmo_reg;

endmodule
